conbox_cfg_loader: RTL and testbench

CONBOX_CFG_LOADER -- requirements
Module: conbox_cfg_loader

---
 rtl/conbox_cfg_loader_pkg.sv | 49 ++++
 rtl/conbox_cfg_loader_if.sv | 27 ++
 rtl/conbox_cfg_loader_cfg_shift_reg.sv | 40 ++++
 rtl/conbox_cfg_loader.sv | 180 ++++++++++++++++++
 tb/tb_conbox_cfg_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conbox_cfg_loader_pkg.sv
// Shared definitions for the connection-box configuration loader:
// width derivations, selection encodings and the loader state type.
// CONBOX_CFG_PARITY_EN adds one trailing even-parity bit per frame.
package conbox_pkg;

  // Bits needed to select one of WIDTH tracks plus the const-0/const-1 inputs
  function automatic int sel_bits_f(input int width);
    return $clog2(width + 2);
  endfunction

  // Config word width of one box side: one selector per LE pin
  function automatic int cfg_bits_f(input int width, input int le_in, input int le_out);
    return (le_in + le_out) * sel_bits_f(width);
  endfunction

  // Box index width, never narrower than one bit
  function automatic int addr_bits_f(input int num_cb);
    return (num_cb > 1) ? $clog2(num_cb) : 1;
  endfunction

  // Selector value that ties an LE pin to constant 0
  function automatic int sel_const0_f(input int width);
    return width;
  endfunction

  // Selector value that ties an LE pin to constant 1
  function automatic int sel_const1_f(input int width);
    return width + 1;
  endfunction

  // All-ones selector leaves an LE pin disconnected
  function automatic int sel_disabled_f(input int width);
    return (1 << sel_bits_f(width)) - 1;
  endfunction

`ifdef CONBOX_CFG_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/conbox_cfg_loader_if.sv
// Serial configuration input and connection-box write bus of the loader.
// master = configuration source / box array side, slave = loader.
interface conbox_cfg_loader_if #(
  parameter int AW       = 2,
  parameter int CFG_BITS = 20
);
  logic                cfg_start;
  logic                cfg_bit;
  logic                cfg_valid;
  logic                cfg_ready;
  logic                cfg_done;
  logic                cfg_err;
  logic                cb_wr_en;
  logic [AW-1:0]       cb_wr_addr;
  logic [CFG_BITS-1:0] cb_dataA;
  logic [CFG_BITS-1:0] cb_dataB;

  modport master (
    output cfg_start, cfg_bit, cfg_valid,
    input  cfg_ready, cfg_done, cfg_err, cb_wr_en, cb_wr_addr, cb_dataA, cb_dataB
  );

  modport slave (
    input  cfg_start, cfg_bit, cfg_valid,
    output cfg_ready, cfg_done, cfg_err, cb_wr_en, cb_wr_addr, cb_dataA, cb_dataB
  );
endinterface

// File: rtl/conbox_cfg_loader_cfg_shift_reg.sv
// Serial-in/parallel-out frame register. The first bit shifted in ends up
// at index 0 after FRAME_BITS shifts. frame_o shows the contents as they
// will stand after the current edge, so the bit accepted on the last edge
// of a frame is already visible to the consumer on that same edge.
module cfg_shift_reg #(
  parameter int FRAME_BITS = 40
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  shift_en_i,
  input  logic                  clr_i,
  input  logic                  ser_i,
  output logic [FRAME_BITS-1:0] frame_o
);
  logic [FRAME_BITS-1:0] par_q;
  logic [FRAME_BITS-1:0] par_d;

  // Next contents: clear wins, otherwise shift right with new bit at the top
  always_comb begin
    par_d = par_q;
    if (clr_i) begin
      par_d = '0;
    end else if (shift_en_i) begin
      par_d = {ser_i, par_q[FRAME_BITS-1:1]};
    end else begin
      par_d = par_q;
    end
  end

  // Frame storage
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign frame_o = par_d;
endmodule

// File: rtl/conbox_cfg_loader.sv
// Connection-box configuration loader: collects serial frames of
// 2*CFG_BITS bits (dataA first, LSB first) and writes each assembled frame
// to the next of NUM_CB connection boxes with a one-cycle strobe.
// Optional feature macro: CONBOX_CFG_PARITY_EN (trailing even-parity bit
// per frame; a bad frame is dropped, flagged and the same box reloaded).
module conbox_cfg_loader
  import conbox_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LE_INPUTS  = 4,
  parameter int LE_OUTPUTS = 1,
  parameter int NUM_CB     = 4
) (
  input logic                clk,
  input logic                n_rst,
  conbox_cfg_loader_if.slave bus
);
  localparam int CFG_BITS   = cfg_bits_f(WIDTH, LE_INPUTS, LE_OUTPUTS);
  localparam int FRAME_BITS = 2 * CFG_BITS + PARITY_BITS;
  localparam int AW         = addr_bits_f(NUM_CB);
  localparam int BCW        = $clog2(FRAME_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
  localparam logic [AW-1:0]  LAST_IDX = AW'(NUM_CB - 1);

  ld_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  err_q, err_d;
  logic [CFG_BITS-1:0]   data_a_q, data_a_d;
  logic [CFG_BITS-1:0]   data_b_q, data_b_d;
  logic [FRAME_BITS-1:0] frame_s;
  logic                  accept_s;
  logic                  last_bit_s;
  logic                  par_ok_s;
  logic                  shift_clr_s;
  logic                  cfg_ready_s;
  logic                  cfg_done_s;
  logic                  cb_wr_en_s;

  assign accept_s    = (state_q == ST_LOAD) && bus.cfg_valid;
  assign last_bit_s  = accept_s && (bit_cnt_q == LAST_BIT);
  assign shift_clr_s = bus.cfg_start || (state_q == ST_WRITE);

`ifdef CONBOX_CFG_PARITY_EN
  assign par_ok_s = ~(^frame_s);
`else
  assign par_ok_s = 1'b1;
`endif

  cfg_shift_reg #(
    .FRAME_BITS (FRAME_BITS)
  ) u_shift (
    .clk        (clk),
    .n_rst      (n_rst),
    .shift_en_i (accept_s),
    .clr_i      (shift_clr_s),
    .ser_i      (bus.cfg_bit),
    .frame_o    (frame_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a start pulse always (re)enters LOAD
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_start) state_d = ST_LOAD;
        else               state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (bus.cfg_start)             state_d = ST_LOAD;
        else if (last_bit_s && par_ok_s) state_d = ST_WRITE;
        else                           state_d = ST_LOAD;
      end
      ST_WRITE: begin
        if (bus.cfg_start)          state_d = ST_LOAD;
        else if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                        state_d = ST_LOAD;
      end
      ST_DONE: begin
        if (bus.cfg_start) state_d = ST_LOAD;
        else               state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the write strobe is withdrawn when a start aborts the write
  always_comb begin
    cfg_ready_s = 1'b0;
    cfg_done_s  = 1'b0;
    cb_wr_en_s  = 1'b0;
    case (state_q)
      ST_LOAD: cfg_ready_s = 1'b1;
      ST_WRITE: begin
        if (bus.cfg_start) cb_wr_en_s = 1'b0;
        else               cb_wr_en_s = 1'b1;
      end
      ST_DONE: cfg_done_s = 1'b1;
      default: begin
        cfg_ready_s = 1'b0;
        cfg_done_s  = 1'b0;
        cb_wr_en_s  = 1'b0;
      end
    endcase
  end

  // Counters, sticky error and output data words
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    if (bus.cfg_start) begin
      bit_cnt_d = '0;
      idx_d     = '0;
      // A restart mid-session is an error; a fresh start clears the flag
      if ((state_q == ST_LOAD) || (state_q == ST_WRITE)) err_d = 1'b1;
      else                                               err_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (last_bit_s) begin
            bit_cnt_d = '0;
            if (par_ok_s) begin
              data_a_d = frame_s[CFG_BITS-1:0];
              data_b_d = frame_s[2*CFG_BITS-1:CFG_BITS];
            end else begin
              err_d = 1'b1;
            end
          end else if (accept_s) begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_WRITE: begin
          bit_cnt_d = '0;
          if (idx_q != LAST_IDX) idx_d = idx_q + AW'(1);
          else                   idx_d = idx_q;
        end
        default: bit_cnt_d = bit_cnt_q;
      endcase
    end
  end

  // Datapath registers; data words reset to the disabled selection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      data_a_q  <= '1;
      data_b_q  <= '1;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
    end
  end

  assign bus.cfg_ready  = cfg_ready_s;
  assign bus.cfg_done   = cfg_done_s;
  assign bus.cfg_err    = err_q;
  assign bus.cb_wr_en   = cb_wr_en_s;
  assign bus.cb_wr_addr = idx_q;
  assign bus.cb_dataA   = data_a_q;
  assign bus.cb_dataB   = data_b_q;
endmodule

// File: tb/tb_conbox_cfg_loader.sv
// Directed bench for conbox_cfg_loader with a write scoreboard.
// Honours CONBOX_CFG_PARITY_EN (adds a bad-parity frame step).
module tb_conbox_cfg_loader;
  import conbox_pkg::*;

  localparam int WIDTH = 8;
  localparam int LE_IN = 4;
  localparam int LE_OUT = 1;
  localparam int NCB = 4;
  localparam int CB = 20;
  localparam int AW = 2;
`ifdef CONBOX_CFG_PARITY_EN
  localparam int FB = 2 * CB + 1;
`else
  localparam int FB = 2 * CB;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [CB-1:0] a;
    logic [CB-1:0] b;
  } wr_t;

  logic clk = 1'b0;
  logic n_rst;
  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int exp_wr_cnt = 0;
  int base_cnt;
  wr_t sb[$];
  logic [CB-1:0] ones_v = '1;
  logic [CB-1:0] a_v;
  logic [FB-1:0] f_v;

  conbox_cfg_loader_if #(.AW(AW), .CFG_BITS(CB)) bus ();

  conbox_cfg_loader #(
    .WIDTH(WIDTH), .LE_INPUTS(LE_IN), .LE_OUTPUTS(LE_OUT), .NUM_CB(NCB)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CB-1:0] rnd_word();
    logic [CB-1:0] r;
    for (int i = 0; i < CB; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [FB-1:0] mk_frame(input logic [CB-1:0] a, input logic [CB-1:0] b);
    logic [FB-1:0] f;
    f[CB-1:0] = a;
    f[2*CB-1:CB] = b;
`ifdef CONBOX_CFG_PARITY_EN
    f[FB-1] = ^{a, b};
`endif
    return f;
  endfunction

  task automatic start_pulse();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // Offer one bit until the loader takes it (bounded)
  task automatic send_bit(input logic b);
    bus.cfg_bit = b;
    bus.cfg_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.cfg_ready === 1'b1) begin
        tick();
        bus.cfg_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.cfg_valid = 1'b0;
    n_checks++;
    n_fail++;
    $error("FAIL bit_accept_timeout: observed no cfg_ready expected cfg_ready within 20 cycles");
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input int nbits, input bit gap,
                            input bit exp_wr, input int addr);
    wr_t e;
    if (exp_wr) begin
      e.addr = AW'(addr);
      e.a = f[CB-1:0];
      e.b = f[2*CB-1:CB];
      sb.push_back(e);
      exp_wr_cnt++;
    end
    for (int k = 0; k < nbits; k++) begin
      send_bit(f[k]);
      if (gap && (k != nbits - 1)) tick();
    end
    if (exp_wr) begin
      @(negedge clk);
      chk("wr_latency", bus.cb_wr_en, 1);
      tick();
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.cb_wr_en === 1'b1) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {62'd0, bus.cb_wr_addr}, 64'hFFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", bus.cb_wr_addr, e.addr);
        chk("wr_dataA", bus.cb_dataA, e.a);
        chk("wr_dataB", bus.cb_dataB, e.b);
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_bit = 1'b0;
    bus.cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.cfg_ready, 0);
    chk("rst_done", bus.cfg_done, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_wr_en", bus.cb_wr_en, 0);
    chk("rst_addr", bus.cb_wr_addr, 0);
    chk("rst_dataA", bus.cb_dataA, ones_v);
    chk("rst_dataB", bus.cb_dataB, ones_v);
    tick();
    n_rst = 1'b1;
    tick();

    // Four frames with valid toggling; frame 0 selects track 1 on A mux 0
    start_pulse();
    @(negedge clk);
    chk("load_ready", bus.cfg_ready, 1);
    chk("load_err", bus.cfg_err, 0);
    tick();
    a_v = '1;
    a_v[3:0] = 4'h1;
    send_frame(mk_frame(a_v, ones_v), FB, 1'b1, 1'b1, 0);
    for (int i = 1; i < NCB; i++) send_frame(mk_frame(rnd_word(), rnd_word()), FB, 1'b1, 1'b1, i);
    @(negedge clk);
    chk("done_set", bus.cfg_done, 1);
    chk("done_ready", bus.cfg_ready, 0);
    chk("wr_count_4", wr_cnt, exp_wr_cnt);
    tick();

    // Valid held in DONE is ignored
    base_cnt = wr_cnt;
    bus.cfg_bit = 1'b1;
    bus.cfg_valid = 1'b1;
    repeat (50) tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("done_no_wr", wr_cnt, base_cnt);
    chk("done_hold", bus.cfg_done, 1);
    chk("done_no_ready", bus.cfg_ready, 0);
    tick();

    // Abort after 17 bits of the second frame
    start_pulse();
    @(negedge clk);
    chk("restart_err_clr", bus.cfg_err, 0);
    chk("restart_done_clr", bus.cfg_done, 0);
    tick();
    send_frame(mk_frame(rnd_word(), rnd_word()), FB, 1'b0, 1'b1, 0);
    send_frame(mk_frame(rnd_word(), rnd_word()), 17, 1'b0, 1'b0, 1);
    start_pulse();
    @(negedge clk);
    chk("abort_err", bus.cfg_err, 1);
    chk("abort_ready", bus.cfg_ready, 1);
    tick();
    for (int i = 0; i < NCB; i++) send_frame(mk_frame(rnd_word(), rnd_word()), FB, 1'b0, 1'b1, i);
    @(negedge clk);
    chk("abort_done", bus.cfg_done, 1);
    chk("err_sticky", bus.cfg_err, 1);
    tick();

    // Reset after 30 bits of a frame
    start_pulse();
    send_frame(mk_frame(rnd_word(), rnd_word()), 30, 1'b0, 1'b0, 0);
    base_cnt = wr_cnt;
    n_rst = 1'b0;
    @(negedge clk);
    chk("mrst_dataA", bus.cb_dataA, ones_v);
    chk("mrst_dataB", bus.cb_dataB, ones_v);
    chk("mrst_ready", bus.cfg_ready, 0);
    chk("mrst_err", bus.cfg_err, 0);
    chk("mrst_addr", bus.cb_wr_addr, 0);
    tick();
    n_rst = 1'b1;
    bus.cfg_valid = 1'b1;
    repeat (50) tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_wr", wr_cnt, base_cnt);
    chk("idle_ready", bus.cfg_ready, 0);
    chk("idle_done", bus.cfg_done, 0);
    tick();

    start_pulse();
`ifdef CONBOX_CFG_PARITY_EN
    // Corrupted parity: dropped, flagged, same box reloaded
    f_v = mk_frame(rnd_word(), rnd_word());
    f_v[FB-1] = ~f_v[FB-1];
    send_frame(f_v, FB, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("par_err", bus.cfg_err, 1);
    chk("par_ready", bus.cfg_ready, 1);
    chk("par_no_wr", bus.cb_wr_en, 0);
    tick();
`endif
    f_v = mk_frame(rnd_word(), rnd_word());
    send_frame(f_v, FB, 1'b0, 1'b1, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("wr_count_total", wr_cnt, exp_wr_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
